// File: rtl/classifier_pkg.sv
// Shared types and constants for the classifier front end: pixel format,
// window geometry and the window sequencer state encoding.
package classifier_pkg;

    localparam int PIX_W      = 96;
    localparam int WIN        = 20;
    localparam int CLS_ADDR_W = 9;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_WAIT,
        ST_REPORT,
        ST_ADVANCE,
        ST_FINISH
    } seq_state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Window position and pixel address generator. Walks the WIN x WIN pixels
// of the current window in raster order and steps the window across the
// frame. All addressing is incremental: a frame-row base for the window's
// top line and a line base that advances by IMG_W per window row.
module window_addr_gen #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int WIN    = classifier_pkg::WIN,
    parameter int STRIDE = 4,
    parameter int AW     = $clog2(IMG_W*IMG_H)
) (
    input  logic                                CLK,
    input  logic                                RESET_N,
    input  logic                                clr,
    input  logic                                pix_step,
    input  logic                                win_step,
    output logic [AW-1:0]                       pix_addr,
    output logic [classifier_pkg::CLS_ADDR_W-1:0] col,
    output logic                                last_pix,
    output logic                                last_win,
    output logic [15:0]                         win_x,
    output logic [15:0]                         win_y
);
    import classifier_pkg::*;

    localparam int CW = CLS_ADDR_W;

    localparam logic [15:0]   STEP16       = 16'(STRIDE);
    localparam logic [15:0]   X_MAX        = 16'(IMG_W - WIN);
    localparam logic [15:0]   Y_MAX        = 16'(IMG_H - WIN);
    localparam logic [CW-1:0] LAST_IDX     = CW'(WIN - 1);
    localparam logic [AW-1:0] ROW_STEP     = AW'(IMG_W);
    localparam logic [AW-1:0] WIN_ROW_STEP = AW'(IMG_W * STRIDE);

    logic [15:0]   win_x_reg, win_x_next;
    logic [15:0]   win_y_reg, win_y_next;
    logic [AW-1:0] win_row_reg, win_row_next;    // win_y * IMG_W
    logic [AW-1:0] row_base_reg, row_base_next;  // (win_y + row) * IMG_W
    logic [CW-1:0] row_reg, row_next;
    logic [CW-1:0] col_reg, col_next;
    logic          x_fits;
    logic          y_fits;

    // 17-bit compares so a large STRIDE cannot wrap the 16-bit position
    assign x_fits   = ({1'b0, win_x_reg} + {1'b0, STEP16}) <= {1'b0, X_MAX};
    assign y_fits   = ({1'b0, win_y_reg} + {1'b0, STEP16}) <= {1'b0, Y_MAX};
    assign last_win = !x_fits && !y_fits;
    assign last_pix = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);
    assign pix_addr = row_base_reg + AW'(win_x_reg) + AW'(col_reg);
    assign col      = col_reg;
    assign win_x    = win_x_reg;
    assign win_y    = win_y_reg;

    // Next-value logic: frame clear, window step, or pixel step
    always_comb begin
        win_x_next    = win_x_reg;
        win_y_next    = win_y_reg;
        win_row_next  = win_row_reg;
        row_base_next = row_base_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        if (clr) begin
            win_x_next    = '0;
            win_y_next    = '0;
            win_row_next  = '0;
            row_base_next = '0;
            row_next      = '0;
            col_next      = '0;
        end else if (win_step) begin
            row_next = '0;
            col_next = '0;
            if (x_fits) begin
                win_x_next    = win_x_reg + STEP16;
                row_base_next = win_row_reg;
            end else begin
                win_x_next    = '0;
                win_y_next    = win_y_reg + STEP16;
                win_row_next  = win_row_reg + WIN_ROW_STEP;
                row_base_next = win_row_reg + WIN_ROW_STEP;
            end
        end else if (pix_step) begin
            if (col_reg == LAST_IDX) begin
                col_next = '0;
                if (row_reg == LAST_IDX) begin
                    row_next      = '0;
                    row_base_next = win_row_reg;
                end else begin
                    row_next      = row_reg + 1'b1;
                    row_base_next = row_base_reg + ROW_STEP;
                end
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            win_x_reg    <= '0;
            win_y_reg    <= '0;
            win_row_reg  <= '0;
            row_base_reg <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
        end else begin
            win_x_reg    <= win_x_next;
            win_y_reg    <= win_y_next;
            win_row_reg  <= win_row_next;
            row_base_reg <= row_base_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
        end
    end

endmodule

// File: rtl/window_sequencer.sv
// Frame sequencer for the integral-image classifier: raster-scans window
// positions, streams each window's pixels from the frame store into the
// classifier, waits for its result and hands the window coordinates
// downstream over a valid/ready handshake.
module window_sequencer #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int WIN    = classifier_pkg::WIN,
    parameter int STRIDE = 4,
    parameter int AW     = $clog2(IMG_W*IMG_H)
) (
    input  logic                                  CLK,
    input  logic                                  RESET_N,
    input  logic                                  START,
    output logic                                  BUSY,
    output logic                                  DONE,
    output logic                                  RD_EN,
    output logic [AW-1:0]                         RD_ADDR,
    input  classifier_pkg::pixel_t                RD_DATA,
    output logic                                  CLS_START,
    output logic                                  CLS_VALID,
    output logic [classifier_pkg::CLS_ADDR_W-1:0] CLS_ADDR,
    output classifier_pkg::pixel_t                CLS_XYZ,
    input  logic                                  CLS_DONE,
    output logic                                  WIN_VALID,
    input  logic                                  WIN_READY,
    output logic [15:0]                           WIN_X,
    output logic [15:0]                           WIN_Y
);
    import classifier_pkg::*;

    seq_state_t            state_reg, state_next;
    logic                  cls_start_reg, cls_start_next;
    logic                  gen_clr;
    logic                  gen_pix_step;
    logic                  gen_win_step;
    logic                  win_latch;
    logic [AW-1:0]         gen_addr;
    logic [CLS_ADDR_W-1:0] gen_col;
    logic                  gen_last_pix;
    logic                  gen_last_win;
    logic [15:0]           gen_win_x;
    logic [15:0]           gen_win_y;
    logic                  rd_en_reg;
    logic [AW-1:0]         rd_addr_reg;
    logic [CLS_ADDR_W-1:0] rd_col_reg;
    logic                  cls_valid_reg;
    logic [CLS_ADDR_W-1:0] cls_addr_reg;
    logic [15:0]           win_x_out_reg;
    logic [15:0]           win_y_out_reg;

    window_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .WIN    (WIN),
        .STRIDE (STRIDE),
        .AW     (AW)
    ) u_addr_gen (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .clr      (gen_clr),
        .pix_step (gen_pix_step),
        .win_step (gen_win_step),
        .pix_addr (gen_addr),
        .col      (gen_col),
        .last_pix (gen_last_pix),
        .last_win (gen_last_win),
        .win_x    (gen_win_x),
        .win_y    (gen_win_y)
    );

    // State register and the registered classifier start pulse
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ST_IDLE;
            cls_start_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cls_start_reg <= cls_start_next;
        end
    end

    // Next-state logic and counter controls
    always_comb begin
        state_next     = state_reg;
        cls_start_next = 1'b0;
        gen_clr        = 1'b0;
        gen_pix_step   = 1'b0;
        gen_win_step   = 1'b0;
        win_latch      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    gen_clr        = 1'b1;
                    cls_start_next = 1'b1;
                    state_next     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                gen_pix_step = 1'b1;
                if (gen_last_pix) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (CLS_DONE) begin
                    win_latch  = 1'b1;
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (WIN_READY) begin
                    state_next = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (gen_last_win) begin
                    state_next = ST_FINISH;
                end else begin
                    gen_win_step   = 1'b1;
                    cls_start_next = 1'b1;
                    state_next     = ST_FETCH;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read issue stage and the 1-cycle return alignment towards the classifier
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            rd_col_reg    <= '0;
            cls_valid_reg <= 1'b0;
            cls_addr_reg  <= '0;
        end else begin
            rd_en_reg <= (state_reg == ST_FETCH);
            if (state_reg == ST_FETCH) begin
                rd_addr_reg <= gen_addr;
                rd_col_reg  <= gen_col;
            end
            cls_valid_reg <= rd_en_reg;
            cls_addr_reg  <= rd_col_reg;
        end
    end

    // Coordinates of the finished window, frozen for the whole report
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            win_x_out_reg <= '0;
            win_y_out_reg <= '0;
        end else if (win_latch) begin
            win_x_out_reg <= gen_win_x;
            win_y_out_reg <= gen_win_y;
        end
    end

    assign BUSY      = (state_reg != ST_IDLE) && (state_reg != ST_FINISH);
    assign DONE      = (state_reg == ST_FINISH);
    assign RD_EN     = rd_en_reg;
    assign RD_ADDR   = rd_addr_reg;
    assign CLS_START = cls_start_reg;
    assign CLS_VALID = cls_valid_reg;
    assign CLS_ADDR  = cls_addr_reg;
    // The frame store's output register is the pipeline stage; gate so the
    // classifier bus is quiet outside valid beats and during reset.
    assign CLS_XYZ   = cls_valid_reg ? RD_DATA : '0;
    assign WIN_VALID = (state_reg == ST_REPORT);
    assign WIN_X     = win_x_out_reg;
    assign WIN_Y     = win_y_out_reg;

endmodule

// File: tb/tb_window_sequencer.sv
// Directed bench for window_sequencer on a 24x22 frame with 4-pixel stride:
// two windows per frame, classifier and frame store modelled in the bench.
module tb_window_sequencer;

    localparam int IMG_W  = 24;
    localparam int IMG_H  = 22;
    localparam int WIN    = 20;
    localparam int STRIDE = 4;
    localparam int AW     = $clog2(IMG_W*IMG_H);

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          START = 1'b0;
    logic          CLS_DONE = 1'b0;
    logic          WIN_READY = 1'b0;
    logic [95:0]   RD_DATA = '0;
    logic          BUSY, DONE, RD_EN, CLS_START, CLS_VALID, WIN_VALID;
    logic [AW-1:0] RD_ADDR;
    logic [8:0]    CLS_ADDR;
    logic [95:0]   CLS_XYZ;
    logic [15:0]   WIN_X, WIN_Y;

    window_sequencer #(
        .IMG_W (IMG_W), .IMG_H (IMG_H), .WIN (WIN), .STRIDE (STRIDE), .AW (AW)
    ) dut (
        .CLK (CLK), .RESET_N (RESET_N), .START (START), .BUSY (BUSY), .DONE (DONE),
        .RD_EN (RD_EN), .RD_ADDR (RD_ADDR), .RD_DATA (RD_DATA),
        .CLS_START (CLS_START), .CLS_VALID (CLS_VALID), .CLS_ADDR (CLS_ADDR),
        .CLS_XYZ (CLS_XYZ), .CLS_DONE (CLS_DONE),
        .WIN_VALID (WIN_VALID), .WIN_READY (WIN_READY), .WIN_X (WIN_X), .WIN_Y (WIN_Y)
    );

    always #5 CLK = ~CLK;

    // Frame store contents as a function of address
    function automatic logic [95:0] pix(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {w ^ 32'hA5A5_5A5A, w * 32'd7 + 32'd3, ~w};
    endfunction

    // Frame store: data one cycle after the read strobe
    always @(posedge CLK) begin
        if (RD_EN) RD_DATA <= pix(RD_ADDR);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_reads, n_valid, n_win, n_done, exp_col, win_idx, addr_n, clash;
    int done_delay, done_wait;
    logic          prev_en;
    logic [AW-1:0] prev_addr;
    logic          busy_at_done;
    logic [AW-1:0] addr_log [21];
    logic [15:0]   xlog [4];
    logic [15:0]   ylog [4];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock: sample at the falling edge, track the stream, model classifier DONE
    task automatic tick();
        logic        xfer;
        logic [15:0] tx, ty;
        xfer = WIN_VALID && WIN_READY;
        tx   = WIN_X;
        ty   = WIN_Y;
        @(negedge CLK);
        if (xfer) begin
            if (n_win < 4) begin xlog[n_win] = tx; ylog[n_win] = ty; end
            n_win++;
        end
        if (CLS_START && CLS_VALID) clash++;
        if (CLS_START) begin
            win_idx++; addr_n = 0; exp_col = 0; n_valid = 0;
            CLS_DONE = 1'b0; done_wait = -1;
        end
        if (RESET_N) check("cls_valid_trail", 128'(CLS_VALID), 128'(prev_en));
        if (CLS_VALID) begin
            check("cls_addr", 128'(CLS_ADDR), 128'(exp_col));
            check("cls_xyz", 128'(CLS_XYZ), 128'(pix(prev_addr)));
            exp_col = (exp_col == WIN-1) ? 0 : exp_col + 1;
            n_valid++;
            if (n_valid == WIN*WIN) done_wait = done_delay;
        end
        if (RD_EN) begin
            n_reads++;
            if (win_idx == 1 && addr_n < 21) addr_log[addr_n] = RD_ADDR;
            addr_n++;
        end
        prev_en   = RD_EN;
        prev_addr = RD_ADDR;
        if (DONE) begin n_done++; busy_at_done = BUSY; end
        if (done_wait == 0) begin CLS_DONE = 1'b1; done_wait = -1; end
        else if (done_wait > 0) done_wait--;
    endtask

    task automatic start_frame(input string tag);
        n_reads = 0; n_win = 0; n_done = 0; win_idx = -1; busy_at_done = 1'b1;
        for (int k = 0; k < 4; k++) begin xlog[k] = 16'hFFFF; ylog[k] = 16'hFFFF; end
        START = 1'b1;
        tick();
        START = 1'b0;
        check({tag, "_cls_start"}, 128'(CLS_START), 128'(1));
        check({tag, "_busy"}, 128'(BUSY), 128'(1));
        check({tag, "_no_read_yet"}, 128'(RD_EN), 128'(0));
        tick();
        check({tag, "_first_rd_en"}, 128'(RD_EN), 128'(1));
        check({tag, "_first_rd_addr"}, 128'(RD_ADDR), 128'(0));
    endtask

    task automatic run_to_done(input string tag);
        int i;
        i = 0;
        while (n_done == 0 && i < 3000) begin tick(); i++; end
        check({tag, "_done_seen"}, 128'(n_done > 0), 128'(1));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 128'({BUSY, DONE, RD_EN, CLS_START, CLS_VALID, WIN_VALID}), 128'(0));
        check({tag, "_rd_addr"}, 128'(RD_ADDR), 128'(0));
        check({tag, "_cls_addr"}, 128'(CLS_ADDR), 128'(0));
        check({tag, "_cls_xyz"}, 128'(CLS_XYZ), 128'(0));
        check({tag, "_win_xy"}, 128'({WIN_X, WIN_Y}), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int r0;
        int wv;
        int nw;
        n_reads = 0; n_valid = 0; n_win = 0; n_done = 0; exp_col = 0; win_idx = -1;
        addr_n = 0; clash = 0; done_delay = 0; done_wait = -1;
        prev_en = 1'b0; prev_addr = '0; busy_at_done = 1'b1;

        // Reset state
        repeat (3) tick();
        check_outputs_zero("reset");
        RESET_N = 1'b1;
        tick();

        // Full frame, classifier done right after last pixel, START while busy and on DONE
        WIN_READY = 1'b1; done_delay = 0;
        start_frame("frame_a");
        i = 0;
        while (n_done == 0 && i < 3000) begin START = (i == 100); tick(); i++; end
        START = 1'b0;
        check("frame_a_done_seen", 128'(n_done > 0), 128'(1));
        START = 1'b1;
        tick();
        START = 1'b0;
        check("done_start_ignored_busy", 128'(BUSY), 128'(0));
        check("done_start_ignored_cls_start", 128'(CLS_START), 128'(0));
        repeat (30) tick();
        check("frame_a_done_count", 128'(n_done), 128'(1));
        check("frame_a_reads", 128'(n_reads), 128'(800));
        check("frame_a_windows", 128'(n_win), 128'(2));
        check("frame_a_win0_xy", 128'({xlog[0], ylog[0]}), 128'({16'd0, 16'd0}));
        check("frame_a_win1_xy", 128'({xlog[1], ylog[1]}), 128'({16'd4, 16'd0}));
        check("busy_low_with_done", 128'(busy_at_done), 128'(0));
        for (int k = 0; k < 20; k++) check("win1_row0_addr", 128'(addr_log[k]), 128'(4 + k));
        check("win1_row1_addr", 128'(addr_log[20]), 128'(28));

        // Slow classifier and stalled downstream
        WIN_READY = 1'b0; done_delay = 50;
        start_frame("frame_b");
        i = 0;
        while (n_valid < WIN*WIN && i < 1000) begin tick(); i++; end
        check("frame_b_last_valid_seen", 128'(n_valid), 128'(WIN*WIN));
        r0 = n_reads; wv = 0; i = 0;
        while (!CLS_DONE && i < 200) begin tick(); if (WIN_VALID) wv++; i++; end
        check("wait_cls_done_seen", 128'(CLS_DONE), 128'(1));
        check("wait_no_report", 128'(wv), 128'(0));
        check("wait_no_extra_reads", 128'(n_reads), 128'(r0));
        check("wait_reads_one_window", 128'(r0), 128'(400));
        check("wait_busy", 128'(BUSY), 128'(1));
        tick();
        check("report_latency", 128'(WIN_VALID), 128'(1));
        for (int k = 0; k < 10; k++) begin
            tick();
            check("report_hold", 128'({WIN_VALID, WIN_X, WIN_Y}), 128'({1'b1, 16'd0, 16'd0}));
        end
        check("report_no_transfer_while_stalled", 128'(n_win), 128'(0));
        WIN_READY = 1'b1; done_delay = 0; nw = n_win;
        tick();
        check("report_one_transfer", 128'(n_win), 128'(nw + 1));
        check("report_valid_drops", 128'(WIN_VALID), 128'(0));
        check("report_xy", 128'({xlog[0], ylog[0]}), 128'({16'd0, 16'd0}));
        run_to_done("frame_b");
        check("frame_b_windows", 128'(n_win), 128'(2));
        check("frame_b_win1_xy", 128'({xlog[1], ylog[1]}), 128'({16'd4, 16'd0}));

        // Reset in the middle of window 0, then a clean restart
        repeat (3) tick();
        start_frame("frame_c");
        i = 0;
        while (n_reads < 150 && i < 1000) begin tick(); i++; end
        check("frame_c_read_150", 128'(n_reads), 128'(150));
        #2;
        RESET_N = 1'b0;
        #1;
        check_outputs_zero("midframe_reset");
        prev_en = 1'b0; CLS_DONE = 1'b0; done_wait = -1; n_valid = 0; exp_col = 0;
        repeat (2) tick();
        check("midframe_reset_no_report", 128'(n_win), 128'(0));
        RESET_N = 1'b1;
        tick();
        start_frame("restart");
        run_to_done("restart");
        check("restart_windows", 128'(n_win), 128'(2));
        check("restart_win0_xy", 128'({xlog[0], ylog[0]}), 128'({16'd0, 16'd0}));
        check("restart_reads", 128'(n_reads), 128'(800));
        check("start_valid_never_coincide", 128'(clash), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/window_sequencer.md
# window_sequencer

Sequencer that drives the integral-image `Classifier` datapath across a full frame. It raster-scans window positions over a frame stored in pixel memory and streams each 20x20 window of 96-bit XYZ pixels into the classifier one line at a time. It then waits for the classifier's DONE and reports each finished window's coordinates to the downstream stage through a valid/ready handshake. It sits between the frame-store read port and the `Classifier` instance.

## Interface
- `IMG_W`, default 320: frame width in pixels.
- `IMG_H`, default 240: frame height in pixels.
- `WIN`, default 20: window edge; must equal the classifier's line length.
- `STRIDE`, default 4: window step in x and y, 1..WIN.
- `AW`, default `$clog2(IMG_W*IMG_H)`: pixel memory address width.
- `CLK  in  1`: clock, rising edge.
- `RESET_N  in  1`: reset, asynchronous, active-low.
- `START  in  1`: one-cycle frame start request; honoured only in IDLE.
- `BUSY  out  1`: high from the cycle after an accepted START until FINISH.
- `DONE  out  1`: one-cycle pulse when the frame is complete.
- `RD_EN  out  1`: pixel memory read strobe.
- `RD_ADDR  out  AW`: pixel address, row-major, `y*IMG_W+x`.
- `RD_DATA  in  96`: read data, valid exactly 1 cycle after `RD_EN`.
- `CLS_START  out  1`: one-cycle pulse at window start; clears the classifier's sticky DONE.
- `CLS_VALID  out  1`: `CLS_ADDR`/`CLS_XYZ` valid this cycle.
- `CLS_ADDR  out  9`: column index 0..WIN-1 within the current window line.
- `CLS_XYZ  out  96`: pixel to the classifier (registered `RD_DATA`).
- `CLS_DONE  in  1`: classifier result ready, level.
- `WIN_VALID  out  1`: window result available.
- `WIN_READY  in  1`: downstream accepts the result.
- `WIN_X`, `WIN_Y  out  16`: top-left coordinates of the reported window.

## Operation
- States:
  - IDLE.
  - FETCH: issue WIN*WIN reads.
  - DRAIN: last read returning.
  - WAIT: wait for CLS_DONE.
  - REPORT: hold WIN_VALID.
  - ADVANCE: step the window position.
  - FINISH: pulse DONE, then return to IDLE.
- IDLE + START: clear win_x=win_y=0, pulse CLS_START, go to FETCH.
- FETCH issues one read per cycle, with row r 0..WIN-1 and column c 0..WIN-1.
  - Address is `(win_y+r)*IMG_W + win_x + c`, kept incrementally with a row-base register (+IMG_W per row). No multiplier.
  - After the read at r=c=WIN-1, go to DRAIN.
- Each return cycle: CLS_VALID=1, CLS_ADDR=c of that read (delayed 1 cycle), CLS_XYZ=RD_DATA.
- DRAIN goes to WAIT after one cycle.
- WAIT: when CLS_DONE=1, latch win_x/win_y onto WIN_X/WIN_Y and go to REPORT.
- REPORT: WIN_VALID=1. On WIN_VALID & WIN_READY, go to ADVANCE. WIN_X/WIN_Y are stable while WIN_VALID is high.
- ADVANCE:
  - If win_x+STRIDE <= IMG_W-WIN: win_x += STRIDE.
  - Else win_x=0 and win_y += STRIDE. If the new win_y > IMG_H-WIN, go to FINISH.
  - Otherwise pulse CLS_START and go to FETCH.
- Window count: ((IMG_W-WIN)/STRIDE+1) * ((IMG_H-WIN)/STRIDE+1), integer division. Partial windows are never issued.
- START outside IDLE is ignored.
- There is no WAIT timeout. A classifier that never raises CLS_DONE holds the block in WAIT until reset.

## Timing
- Reset values: all outputs 0; state IDLE; internal counters 0.
- RESET_N low mid-frame immediately forces IDLE and all outputs to 0. The in-flight window is discarded and not reported.
- START at cycle t:
  - CLS_START=1 and BUSY=1 at t+1.
  - First RD_EN at t+2, continuous for WIN*WIN cycles.
  - CLS_VALID trails RD_EN by exactly 1 cycle with no gaps.
- CLS_START for each window precedes that window's first CLS_VALID by 2 cycles. CLS_START never coincides with CLS_VALID.
- The earliest WIN_VALID is 1 cycle after CLS_DONE is sampled high in WAIT.
- CLS_DONE high before WAIT (stale) is ignored.
- Handshake: a transfer occurs when WIN_VALID & WIN_READY are high on the same edge. WIN_READY already high on entry gives a 1-cycle REPORT.
- DONE pulses 1 cycle in FINISH. BUSY drops in the same cycle as DONE.
- A START coincident with DONE is ignored. START is accepted from the next cycle.

## Structure
- Package `classifier_pkg`:
  - `PIX_W=96`, `WIN=20`, `CLS_ADDR_W=9`.
  - typedef `pixel_t` (logic [95:0]).
  - enum `seq_state_t` for the states above.
- One natural sub-module, `window_addr_gen`. It holds the r/c/row-base/win_x/win_y counters and produces RD_ADDR, last-pixel and last-window flags.
- The FSM, handshake and 1-cycle return pipeline stay in `window_sequencer`.

## Test plan
- IMG_W=24, IMG_H=22, STRIDE=4, CLS_DONE tied high after the last CLS_VALID:
  - Exactly 2 windows reported, (0,0) then (4,0).
  - DONE pulses once; 800 reads total.
- Window (4,0) in the same config:
  - RD_ADDR sequence starts 4,5,…,23, then 28.
  - CLS_ADDR cycles 0..19 twenty times; CLS_XYZ equals the memory model contents.
- WIN_READY held low 10 cycles in REPORT: WIN_VALID and WIN_X/WIN_Y stay stable, then one transfer on the first READY cycle.
- CLS_DONE delayed 50 cycles after DRAIN: the block stays in WAIT, no extra reads, WIN_VALID 1 cycle after CLS_DONE.
- RESET_N asserted at read 150 of window 0: all outputs 0 immediately. A new START restarts from (0,0) with RD_ADDR=0.
- START pulsed while BUSY and again on the DONE cycle: both ignored, frame count remains 1.
